// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the tri-state register bus read controller.
package bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // Wide enough for any supported register count; callers slice to NrOfRegs.
  localparam logic [63:0] CS_RELEASED = {64{1'b1}};

endpackage

// File: rtl/cs_decoder.sv
// Combinational register index to active-low one-hot select, with out-of-range flag.
module cs_decoder
  import bus_ctrl_pkg::*;
#(
  parameter int NrOfRegs = 8,
  parameter int AddrBits = 3
) (
  input  logic [AddrBits-1:0] addr,
  output logic [NrOfRegs-1:0] cs_n,
  output logic                out_of_range
);

  localparam logic [31:0] REGS_LIMIT = 32'(NrOfRegs);

  // Decode the index; an illegal index leaves every select released.
  always_comb begin
    cs_n         = CS_RELEASED[NrOfRegs-1:0];
    out_of_range = 1'b0;
    if (32'(addr) >= REGS_LIMIT) begin
      out_of_range = 1'b1;
    end else begin
      for (int i = 0; i < NrOfRegs; i++) begin
        if (32'(addr) == 32'(i)) begin
          cs_n[i] = 1'b0;
        end else begin
          cs_n[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_read_controller.sv
// Read initiator for the shared tri-state register bus: selects one register,
// waits the settle time, captures the bus and returns it on a valid/ready channel.
module bus_read_controller
  import bus_ctrl_pkg::*;
#(
  parameter int NrOfBits     = 8,
  parameter int NrOfRegs     = 8,
  parameter int AddrBits     = 3,
  parameter int SettleCycles = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                req_valid,
  input  logic [AddrBits-1:0] req_addr,
  output logic                req_ready,
  input  logic [NrOfBits-1:0] bus,
  output logic [NrOfRegs-1:0] cs,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [NrOfBits-1:0] resp_data,
  output logic                resp_err
);

  localparam logic [CNT_W-1:0]    SETTLE_INIT = CNT_W'(SettleCycles - 1);
  localparam logic [NrOfRegs-1:0] CS_IDLE     = CS_RELEASED[NrOfRegs-1:0];

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [NrOfRegs-1:0]  dec_cs_s;
  logic                 dec_oor_s;
  logic                 en_s;

  assign en_s = ClockEnable & Tick;

  cs_decoder #(
    .NrOfRegs (NrOfRegs),
    .AddrBits (AddrBits)
  ) u_cs_decoder (
    .addr         (req_addr),
    .cs_n         (dec_cs_s),
    .out_of_range (dec_oor_s)
  );

  // Request FSM with settle counter, capture register and registered selects.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      cs         <= CS_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= {NrOfBits{1'b0}};
      resp_err   <= 1'b0;
    end else if (en_s) begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (dec_oor_s) begin
              resp_data  <= {NrOfBits{1'b0}};
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state_r    <= ST_RESP;
            end else begin
              cs      <= dec_cs_s;
              cnt_r   <= SETTLE_INIT;
              state_r <= ST_SETTLE;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - 1'b1;
          end else begin
            // Release the bus on the same edge that samples it.
            resp_data  <= bus;
            resp_err   <= 1'b0;
            cs         <= CS_IDLE;
            resp_valid <= 1'b1;
            state_r    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            resp_valid <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          cs         <= CS_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

endmodule
